// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: size codes, FSM
// encoding, access byte counts and the stall bus codes used by the stall unit.
package mem_ctrl_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IF_RD,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_DONE
    } state_t;

    // Stall bus codes consumed alongside busy/done by the stall controller.
    typedef enum logic [1:0] {
        PASS,
        HOLD,
        BUBB
    } stall_t;

    // Number of byte cycles for a size code; the reserved code 11 acts as a word.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            SZ_B:    byte_count = 3'd1;
            SZ_H:    byte_count = 3'd2;
            default: byte_count = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates the byte-wide synchronous RAM between instruction fetch and load/store.
// Optional MEM_CTRL_IF_ABORT_EN: flush aborts an in-flight fetch instead of dropping its done.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    input  logic              flush,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    state_t              state_reg, state_next;
    logic [2:0]          cnt_reg, cnt_next;
    logic [2:0]          n_reg, n_next;
    logic [ADDR_W-1:0]   base_reg, base_next;
    logic [31:0]         wdata_reg, wdata_next;
    logic [31:0]         buf_reg, buf_next;
    logic                drop_reg, drop_next;
    logic [ADDR_W-1:0]   ram_addr_reg, ram_addr_next;
    logic                ram_we_reg, ram_we_next;
    logic [7:0]          ram_dout_reg, ram_dout_next;
    logic                if_done_reg, if_done_next;
    logic                mem_done_reg, mem_done_next;
    logic [31:0]         if_data_reg, if_data_next;
    logic [31:0]         mem_rdata_reg, mem_rdata_next;

    // Upper address bits lie outside the RAM and are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

    // Byte for base+k arrives two edges after it is issued, so lane cnt-2 is filled.
    logic [2:0]  cap_pos;
    logic        capture;
    logic [31:0] asm_word;

    assign cap_pos = cnt_reg - 3'd2;
    assign capture = (cnt_reg >= 3'd2);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign asm_word[8*gi +: 8] = (capture && cap_pos == 3'(gi)) ? ram_din
                                                                        : buf_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            n_reg         <= '0;
            base_reg      <= '0;
            wdata_reg     <= '0;
            buf_reg       <= '0;
            drop_reg      <= 1'b0;
            ram_addr_reg  <= '0;
            ram_we_reg    <= 1'b0;
            ram_dout_reg  <= '0;
            if_done_reg   <= 1'b0;
            mem_done_reg  <= 1'b0;
            if_data_reg   <= '0;
            mem_rdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            n_reg         <= n_next;
            base_reg      <= base_next;
            wdata_reg     <= wdata_next;
            buf_reg       <= buf_next;
            drop_reg      <= drop_next;
            ram_addr_reg  <= ram_addr_next;
            ram_we_reg    <= ram_we_next;
            ram_dout_reg  <= ram_dout_next;
            if_done_reg   <= if_done_next;
            mem_done_reg  <= mem_done_next;
            if_data_reg   <= if_data_next;
            mem_rdata_reg <= mem_rdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        n_next         = n_reg;
        base_next      = base_reg;
        wdata_next     = wdata_reg;
        buf_next       = buf_reg;
        drop_next      = drop_reg;
        ram_addr_next  = ram_addr_reg;
        ram_we_next    = 1'b0;
        ram_dout_next  = ram_dout_reg;
        if_done_next   = 1'b0;
        mem_done_next  = 1'b0;
        if_data_next   = if_data_reg;
        mem_rdata_next = mem_rdata_reg;

        case (state_reg)
            ST_IDLE: begin
                if (mem_req) begin
                    base_next     = mem_addr[ADDR_W-1:0];
                    n_next        = byte_count(mem_size);
                    wdata_next    = mem_wdata;
                    buf_next      = '0;
                    cnt_next      = 3'd1;
                    drop_next     = 1'b0;
                    ram_addr_next = mem_addr[ADDR_W-1:0];
                    if (mem_we) begin
                        ram_we_next   = 1'b1;
                        ram_dout_next = mem_wdata[7:0];
                        state_next    = ST_MEM_WR;
                    end else begin
                        state_next    = ST_MEM_RD;
                    end
                end else if (if_req && !flush) begin
                    base_next     = if_addr[ADDR_W-1:0];
                    n_next        = 3'd4;
                    buf_next      = '0;
                    cnt_next      = 3'd1;
                    drop_next     = 1'b0;
                    ram_addr_next = if_addr[ADDR_W-1:0];
                    state_next    = ST_IF_RD;
                end
            end

            ST_IF_RD, ST_MEM_RD: begin
                cnt_next = cnt_reg + 3'd1;
                buf_next = asm_word;
                if (cnt_reg < n_reg)
                    ram_addr_next = base_reg + ADDR_W'(cnt_reg);
                if (cnt_reg == n_reg + 3'd1) begin
                    state_next = ST_DONE;
                    if (state_reg == ST_MEM_RD) begin
                        mem_done_next  = 1'b1;
                        mem_rdata_next = asm_word;
                    end else if (!(drop_reg || flush)) begin
                        if_done_next = 1'b1;
                        if_data_next = asm_word;
                    end
                end
                if (state_reg == ST_IF_RD) begin
`ifdef MEM_CTRL_IF_ABORT_EN
                    if (flush) begin
                        state_next   = ST_IDLE;
                        if_done_next = 1'b0;
                        if_data_next = if_data_reg;
                    end
`else
                    drop_next = drop_reg | flush;
`endif
                end
            end

            ST_MEM_WR: begin
                cnt_next = cnt_reg + 3'd1;
                if (cnt_reg < n_reg) begin
                    ram_addr_next = base_reg + ADDR_W'(cnt_reg);
                    ram_we_next   = 1'b1;
                    ram_dout_next = wdata_reg[{cnt_reg[1:0], 3'b000} +: 8];
                end else begin
                    state_next    = ST_DONE;
                    mem_done_next = 1'b1;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_reg != ST_IDLE);
    assign ram_addr  = ram_addr_reg;
    assign ram_we    = ram_we_reg;
    assign ram_dout  = ram_dout_reg;
    assign if_done   = if_done_reg;
    assign mem_done  = mem_done_reg;
    assign if_data   = if_data_reg;
    assign mem_rdata = mem_rdata_reg;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Arbitrates the single byte-wide synchronous RAM port between instruction fetch (IF) and the load/store stage (MEM).
- Serialises 1/2/4-byte accesses into byte cycles and assembles or splits little-endian words.
- Returns one-cycle done pulses that the stall logic uses to release IF and MEM from Hold.
- Sits between the pipeline front end (the PC/IF stages) and the memory/RAM interface.

Parameters:
- ADDR_W, 17: width of ram_addr. Only the low ADDR_W bits of request addresses are driven; upper bits are ignored.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch request; held with if_addr until if_done or flush
- if_addr  in  32  fetch address, word-aligned
- if_done  out  1  one-cycle pulse; if_data valid in the same cycle
- if_data  out  32  fetched instruction
- mem_req  in  1  load/store request; held with operands until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_size  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- mem_addr  in  32  load/store address; alignment is not checked
- mem_wdata  in  32  store data; low bytes are used first
- mem_done  out  1  one-cycle pulse; mem_rdata valid in the same cycle
- mem_rdata  out  32  load data, zero-extended (the MEM stage sign-extends)
- flush  in  1  branch redirect; cancels a pending or in-flight fetch
- busy  out  1  high in every state except IDLE
- ram_addr  out  ADDR_W  byte address, registered
- ram_we  out  1  byte write enable, registered
- ram_dout  out  8  write byte, registered
- ram_din  in  8  read byte, valid one cycle after ram_addr is sampled

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: IDLE. All outputs are 0, including ram_addr, ram_we, if_done, mem_done, if_data and mem_rdata. The byte counter is cleared.
  - Reset mid-operation aborts the access. ram_we is low from the next cycle, and no done pulse is produced.
- States: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- Acceptance: requests are sampled only in IDLE.
  - mem_req wins over if_req when both are high.
  - An if_req sampled with flush high is not accepted.
  - On accept, the controller latches the address, size, write data and requester. N = 4 for IF; N = 1, 2 or 4 for MEM.
- Reads (IF_RD / MEM_RD):
  - Address base+k is issued on the k-th edge after accept, for k = 0..N-1.
  - The byte returned for base+k is placed in bits [8k+7:8k].
  - done is high in the cycle after edge accept+N+1. For a word that is accept+5, so done is high in the 6th cycle.
- Writes (MEM_WR):
  - Byte k of mem_wdata goes out with ram_we=1 at edge accept+k.
  - done is high in the cycle after edge accept+N.
- DONE state:
  - Lasts exactly one cycle; the matching done output is high only during it.
  - Returns to IDLE.
  - The requester drops its req at the edge that ends the done cycle.
- Back-to-back: there is at least one IDLE cycle between accesses. After an IF access, a pending mem_req wins the next arbitration.
- ram_we is low in every state other than MEM_WR. ram_addr holds its last value while idle.
- The address increments modulo 2^ADDR_W, so a fetch at the top of RAM wraps.
- if_data and mem_rdata hold their value until the next access of the same requester completes.
- flush has no effect on MEM accesses.

Optional Feature:
- Macro: MEM_CTRL_IF_ABORT_EN.
- Defined: flush during IF_RD forces IDLE at the next edge. No if_done is produced, and a new if_req can be accepted on the following edge.
- Undefined: flush during IF_RD sets a drop flag. The fetch runs to completion, but the if_done pulse is suppressed.
- In both cases, flush is ignored in the DONE cycle. if_done still pulses, and IF discards it.

Decomposition:
- Shared package holds:
  - size codes SZ_B, SZ_H, SZ_W;
  - the state encoding;
  - byte-count function size -> N;
  - the stall bus codes Pass, Hold and Bubb used by the stall controller that consumes the done/busy signals.
- No sub-module is required. The byte assemble/split logic stays inline.

Test Plan:
- Reset: assert rst for 2 cycles while mem_req=1 -> all outputs 0, no ram_we, busy=0.
- IF word read: RAM bytes at 0x1000 are 13 00 00 93; if_req with if_addr=0x1000 -> ram_addr steps 0x1000..0x1003, if_data=0x93000013, and if_done pulses once, in the 6th cycle after accept.
- Contention: in IDLE, mem_req (store, word, 0x20, 0xDEADBEEF) and if_req arrive together -> RAM writes 0x20=EF, 0x21=BE, 0x22=AD, 0x23=DE. mem_done is high in the 5th cycle after accept, then IF is served and its if_done follows.
- Half load: RAM bytes at 0x31..0x32 are 34 12; load half from 0x31 -> mem_rdata=0x00001234, mem_done in the 4th cycle after accept.
- Flush: flush during the 3rd IF_RD cycle.
  - With MEM_CTRL_IF_ABORT_EN: IDLE next cycle, no if_done, and a new fetch at 0x2000 returns correct data.
  - Without it: no if_done, and busy stays high until the fetch completes.
- Reset mid-store: rst after the 2nd byte of a word store -> only 2 bytes are written, ram_we=0 next cycle, no mem_done.
